mux_sweep_checker: RTL and testbench

MUX_SWEEP_CHECKER -- requirements
Module: mux_sweep_checker

---
 rtl/mux_sweep_checker.sv | 114 +++++++++++
 tb/tb_mux_sweep_checker.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mux_sweep_checker.sv
// mux_sweep_checker
//   Exhaustively exercises a downstream 2:1 mux. Each of the eight {A,B,S}
//   combinations is held for DWELL cycles. On the last dwell cycle of each
//   combination, the returned D is compared against S ? B : A.
//
// Ports
//   CLK      rising-edge clock
//   RST      synchronous active-high reset
//   START    begins a sweep when sampled high in IDLE or FINISH
//   A,B,S    registered drives to the mux under test (A=i[2], B=i[1], S=i[0])
//   D        mux output returned to the checker
//   BUSY     sweep in progress
//   DONE     sweep complete (held in FINISH; a 1-cycle pulse per pass in loop mode)
//   ERR      at least one mismatch seen
//   ERR_CNT  mismatch count, saturating at 15
//   FAIL_IDX index of the first failing combination
//
// Build option
//   MUX_SWEEP_LOOP_EN : when defined, index 7 wraps to index 0 with no idle
//   cycle. DONE pulses at each wrap, and the error state accumulates across
//   passes. Only RST stops the sweep.
module mux_sweep_checker #(
    parameter int DWELL = 25
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    output logic       A,
    output logic       B,
    output logic       S,
    input  logic       D,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic [3:0] ERR_CNT,
    output logic [2:0] FAIL_IDX
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam logic [7:0] LAST = 8'(DWELL - 1);

    logic [1:0] state;
    logic [2:0] idx;
    logic [7:0] cnt;
    logic       exp_d;
    logic       mismatch;

    // A/B/S are registered copies of idx, so they give the expected value directly.
    assign exp_d    = S ? B : A;
    assign mismatch = (D != exp_d);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            idx      <= 3'd0;
            cnt      <= 8'd0;
            A        <= 1'b0;
            B        <= 1'b0;
            S        <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            ERR_CNT  <= 4'd0;
            FAIL_IDX <= 3'd0;
        end else begin
            case (state)
                ST_IDLE, ST_FINISH: begin
                    if (START) begin
                        state     <= ST_DRIVE;
                        idx       <= 3'd0;
                        cnt       <= 8'd0;
                        {A, B, S} <= 3'd0;
                        BUSY      <= 1'b1;
                        DONE      <= 1'b0;
                        ERR       <= 1'b0;
                        ERR_CNT   <= 4'd0;
                        FAIL_IDX  <= 3'd0;
                    end
                end
                ST_DRIVE: begin
`ifdef MUX_SWEEP_LOOP_EN
                    DONE <= 1'b0;
`endif
                    if (cnt == LAST) begin
                        cnt <= 8'd0;
                        if (mismatch) begin
                            ERR <= 1'b1;
                            if (ERR_CNT != 4'hF) ERR_CNT <= ERR_CNT + 4'd1;
                            // ERR still low means this is the first mismatch.
                            if (!ERR) FAIL_IDX <= idx;
                        end
                        // Moving from index 7 back to index 0 also returns A/B/S to 0.
                        idx       <= idx + 3'd1;
                        {A, B, S} <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            DONE <= 1'b1;
`ifndef MUX_SWEEP_LOOP_EN
                            state <= ST_FINISH;
                            BUSY  <= 1'b0;
`endif
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sweep_checker.sv
module tb_mux_sweep_checker;

    localparam int DWELL = 25;

    logic       CLK = 1'b0;
    logic       RST, START, D;
    logic       A, B, S, BUSY, DONE, ERR;
    logic [3:0] ERR_CNT;
    logic [2:0] FAIL_IDX;

    // The model mux drives D: 0 = correct, 1 = tied 0, 2 = select inverted, 3 = tied 1.
    int mode = 0;
    int checks = 0;
    int errors = 0;
    int n;

    always #5 CLK = ~CLK;

    always_comb begin
        D = 1'b0;
        case (mode)
            0: D = S ? B : A;
            1: D = 1'b0;
            2: D = S ? A : B;
            3: D = 1'b1;
            default: D = 1'b0;
        endcase
    end

    mux_sweep_checker #(.DWELL(DWELL)) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .A(A), .B(B), .S(S), .D(D),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .ERR_CNT(ERR_CNT), .FAIL_IDX(FAIL_IDX)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_sweep(input string tag);
        START = 1'b1;
        tick();
        START = 1'b0;
        chk({tag, "_busy"}, BUSY, 1);
        chk({tag, "_done"}, DONE, 0);
        chk({tag, "_clr"}, {ERR, ERR_CNT, FAIL_IDX}, 0);
        chk({tag, "_abs0"}, {A, B, S}, 0);
    endtask

    // Start from the first observation of index 0 and count the cycles until DONE.
    // Each observed cycle must show the index for its dwell window.
    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        do begin
            chk({tag, "_abs"}, {29'd0, A, B, S}, cyc / DWELL);
            tick();
            cyc++;
        end while (!DONE && cyc < 1000);
        chk({tag, "_cycles"}, cyc, 200);
    endtask

    initial begin
        RST = 1'b1;
        START = 1'b0;
        repeat (2) tick();
        chk("rst_outs", {A, B, S, BUSY, DONE, ERR, ERR_CNT, FAIL_IDX}, 0);
        RST = 1'b0;
        repeat (3) tick();
        chk("idle_busy", BUSY, 0);

        // Correct mux: clean sweep of 200 busy cycles.
        mode = 0;
        start_sweep("ok");
        wait_done("ok", n);
        chk("ok_done", DONE, 1);
        chk("ok_err", {ERR, ERR_CNT}, 0);

`ifdef MUX_SWEEP_LOOP_EN
        chk("ok_loop_busy", BUSY, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("loop_rst", {BUSY, DONE, ERR_CNT}, 0);

        // D tied 1 makes indices 0,1,2,5 mismatch: 4 errors per pass.
        mode = 3;
        start_sweep("lp");
        wait_done("lp1", n);
        chk("lp1_busy", BUSY, 1);
        chk("lp1_cnt", ERR_CNT, 4);
        chk("lp1_fidx", FAIL_IDX, 0);
        tick();
        chk("lp1_pulse", DONE, 0);
        n = 0;
        while (!DONE && n < 1000) begin tick(); n++; end
        chk("lp2_gap", n, 199);
        chk("lp2_cnt", ERR_CNT, 8);
        tick();
        n = 0;
        while (!DONE && n < 1000) begin tick(); n++; end
        chk("lp3_cnt", ERR_CNT, 12);
        tick();
        n = 0;
        while (!DONE && n < 1000) begin tick(); n++; end
        chk("lp4_cnt", ERR_CNT, 15);
        chk("lp4_err", ERR, 1);
        chk("lp4_fidx", FAIL_IDX, 0);
`else
        repeat (3) tick();
        chk("fin_hold", {BUSY, DONE, A, B, S}, 5'b01000);

        // D tied 0: the indices expecting 1 are 3,4,6,7.
        mode = 1;
        start_sweep("d0");
        wait_done("d0", n);
        chk("d0_err", ERR, 1);
        chk("d0_cnt", ERR_CNT, 4);
        chk("d0_fidx", FAIL_IDX, 3);

        // Inverted select gives D = S ? A : B. Indices 2 (010), 3 (011), 4 (100)
        // and 5 (101) differ from S ? B : A, so the first failure is index 2.
        mode = 2;
        start_sweep("sinv");
        wait_done("sinv", n);
        chk("sinv_cnt", ERR_CNT, 4);
        chk("sinv_fidx", FAIL_IDX, 2);

        // Reset at cycle 60 aborts the sweep. It also wins over START.
        mode = 0;
        start_sweep("abort");
        repeat (59) tick();
        chk("abort_mid_busy", BUSY, 1);
        RST = 1'b1;
        START = 1'b1;
        tick();
        chk("abort_outs", {A, B, S, BUSY, DONE, ERR, ERR_CNT, FAIL_IDX}, 0);
        tick();
        chk("abort_rst_start", BUSY, 0);
        RST = 1'b0;
        START = 1'b0;
        tick();
        chk("abort_idle", BUSY, 0);
        start_sweep("fresh");
        wait_done("fresh", n);
        chk("fresh_err", {ERR, ERR_CNT}, 0);

        // START held high: only one sweep runs, and the next one starts right after DONE.
        START = 1'b1;
        tick();
        chk("held_busy", BUSY, 1);
        wait_done("held", n);
        chk("held_done", {BUSY, DONE}, 2'b01);
        tick();
        chk("held_restart", {BUSY, DONE}, 2'b10);
        START = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
